// File: rtl/dma_if.sv
// dma_if: CPU/device/memory-side signal bundle of the DMA engine.
interface dma_if;
    logic        cmd;
    logic        BG;
    logic [63:0] edata;
    logic        BR;
    logic        WRITE;
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  offset;
    logic        interrupt;
    modport master (input cmd, BG, edata, output BR, WRITE, addr, data, offset, interrupt);
    modport slave  (output cmd, BG, edata, input BR, WRITE, addr, data, offset, interrupt);
endinterface

// File: rtl/dma_controller.sv
// dma_controller: bus-mastering copy of NUM_BLOCKS 4-word device blocks into memory at BASE_ADDR.
module dma_controller #(
    parameter logic [15:0] BASE_ADDR    = 16'h01F4,
    parameter int          NUM_BLOCKS   = 3,
    parameter int          WRITE_CYCLES = 6
) (
    input logic   clk,
    input logic   reset_n,
    dma_if.master bus
);
    localparam int CW = $clog2(WRITE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    state_t          state;
    logic [1:0]      blk;
    logic [CW-1:0]   cyc;
    logic [1:0]      off;
    logic            br;
    logic            irq;
    logic            wr;
    // A revoked grant gates the strobe immediately; the counters react at the next edge.
    assign wr            = (state == XFER) && bus.BG;
    assign bus.WRITE     = wr;
    assign bus.BR        = br;
    assign bus.interrupt = irq;
    assign bus.offset    = off;
    assign bus.addr      = wr ? BASE_ADDR + {12'd0, blk, 2'b00} : 16'd0;
    assign bus.data      = wr ? bus.edata : 64'd0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            blk   <= '0;
            cyc   <= '0;
            off   <= '0;
            br    <= 1'b0;
            irq   <= 1'b0;
        end else begin
            irq <= 1'b0;
            case (state)
                IDLE: if (bus.cmd) begin
                    state <= REQ;
                    blk   <= '0;
                    cyc   <= '0;
                    br    <= 1'b1;
                end
                REQ: if (bus.BG) begin
                    state <= XFER;
                    off   <= blk;
                end
                XFER: begin
                    if (!bus.BG)
                        cyc <= '0;
                    else if (cyc == CW'(WRITE_CYCLES - 1)) begin
                        cyc <= '0;
                        blk <= blk + 2'd1;
                        if (blk == 2'(NUM_BLOCKS - 1)) begin
                            state <= DONE;
                            br    <= 1'b0;
                            irq   <= 1'b1;
                        end else
                            off <= blk + 2'd1;
                    end else
                        cyc <= cyc + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: per-cycle vector tables for the default engine plus a 1-block/1-cycle instance.
module tb_dma_controller;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   row = -1;
    int   wcount = 0;
    always #5 clk = ~clk;
    dma_if bus1();
    dma_if bus2();
    dma_controller u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    dma_controller #(.NUM_BLOCKS(1), .WRITE_CYCLES(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
    typedef struct {
        logic        c, b, r, br, wr;
        logic [15:0] a;
        logic [1:0]  o;
        logic        irq;
    } vec_t;
    vec_t vq[$];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", nm, row, act, exp);
        end
    endtask
    task automatic push(input logic c, b, r, br, wr, input logic [15:0] a, input logic [1:0] o, input logic irq);
        vq.push_back('{c, b, r, br, wr, a, o, irq});
    endtask
    task automatic idle(input int n, input logic [1:0] o);
        for (int i = 0; i < n; i++) push(0, 0, 1, 0, 0, 0, o, 0);
    endtask
    task automatic blocks(input int from, input int n);
        for (int k = from; k < from + n; k++)
            for (int j = 0; j < 6; j++) push(0, 1, 1, 1, 1, 16'h01F4 + 16'(4 * k), 2'(k), 0);
    endtask
    // cmd in IDLE, `lag` REQ cycles with BG low, then the granted REQ cycle, 18 writes and DONE.
    task automatic push_xfer(input int lag, input logic [1:0] po, input bit busy);
        push(1, 0, 1, 0, 0, 0, po, 0);
        for (int i = 0; i < lag; i++) push(busy && i == 0, 0, 1, 1, 0, 0, po, 0);
        push(0, 1, 1, 1, 0, 0, po, 0);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 6; j++) push(busy && j == 2, 1, 1, 1, 1, 16'h01F4 + 16'(4 * k), 2'(k), 0);
        push(busy, 1, 1, 0, 0, 0, 2, 1);
    endtask
    task automatic run(input string nm);
        foreach (vq[i]) begin
            bus1.cmd   = vq[i].c;
            bus1.BG    = vq[i].b;
            reset_n    = vq[i].r;
            bus1.edata = {$urandom, $urandom};
            #4;
            row = i;
            chk({nm, ".BR"}, 64'(bus1.BR), 64'(vq[i].br));
            chk({nm, ".WRITE"}, 64'(bus1.WRITE), 64'(vq[i].wr));
            chk({nm, ".addr"}, 64'(bus1.addr), 64'(vq[i].a));
            chk({nm, ".offset"}, 64'(bus1.offset), 64'(vq[i].o));
            chk({nm, ".interrupt"}, 64'(bus1.interrupt), 64'(vq[i].irq));
            chk({nm, ".data"}, bus1.data, vq[i].wr ? bus1.edata : 64'd0);
            if (bus1.WRITE) wcount++;
            @(posedge clk);
            #1;
        end
        vq.delete();
        row = -1;
    endtask
    initial begin
        reset_n = 1'b0;
        bus1.cmd = 1'b0; bus1.BG = 1'b0; bus1.edata = '0;
        bus2.cmd = 1'b0; bus2.BG = 1'b0; bus2.edata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #4;
        chk("rst.BR", 64'(bus1.BR), 0);
        chk("rst.WRITE", 64'(bus1.WRITE), 0);
        chk("rst.addr", 64'(bus1.addr), 0);
        chk("rst.offset", 64'(bus1.offset), 0);
        chk("rst.interrupt", 64'(bus1.interrupt), 0);
        chk("rst.data", bus1.data, 0);
        chk("rst2.BR", 64'(bus2.BR), 0);
        @(posedge clk);
        #1;
        idle(3, 0);
        push_xfer(1, 0, 0);
        idle(2, 2);
        wcount = 0;
        run("basic");
        chk("basic.wcount", 64'(wcount), 18);
        push_xfer(20, 2, 0);
        idle(1, 2);
        run("delay");
        push_xfer(1, 2, 1);
        push_xfer(1, 2, 0);
        idle(2, 2);
        run("busy");
        push(1, 0, 1, 0, 0, 0, 2, 0);
        push(0, 0, 1, 1, 0, 0, 2, 0);
        push(0, 1, 1, 1, 0, 0, 2, 0);
        blocks(0, 1);
        for (int j = 0; j < 4; j++) push(0, 1, 1, 1, 1, 16'h01F8, 1, 0);
        for (int j = 0; j < 3; j++) push(0, 0, 1, 1, 0, 0, 1, 0);
        blocks(1, 2);
        push(0, 1, 1, 0, 0, 0, 2, 1);
        idle(1, 2);
        wcount = 0;
        run("revoke");
        chk("revoke.wcount", 64'(wcount), 22);
        push(1, 0, 1, 0, 0, 0, 2, 0);
        push(0, 0, 1, 1, 0, 0, 2, 0);
        push(0, 1, 1, 1, 0, 0, 2, 0);
        for (int j = 0; j < 5; j++) push(0, 1, 1, 1, 1, 16'h01F4, 0, 0);
        push(0, 0, 1, 1, 0, 0, 0, 0);
        blocks(0, 3);
        push(0, 1, 1, 0, 0, 0, 2, 1);
        idle(1, 2);
        wcount = 0;
        run("lastdrop");
        chk("lastdrop.wcount", 64'(wcount), 23);
        push(1, 0, 1, 0, 0, 0, 2, 0);
        push(0, 0, 1, 1, 0, 0, 2, 0);
        push(0, 1, 1, 1, 0, 0, 2, 0);
        blocks(0, 2);
        for (int j = 0; j < 2; j++) push(0, 1, 1, 1, 1, 16'h01FC, 2, 0);
        push(0, 1, 0, 1, 1, 16'h01FC, 2, 0);
        push(0, 1, 1, 0, 0, 0, 0, 0);
        idle(25, 0);
        push_xfer(1, 0, 0);
        idle(1, 2);
        run("midreset");
        bus2.cmd = 1'b1;
        #4;
        chk("sweep.BR0", 64'(bus2.BR), 0);
        @(posedge clk);
        #1;
        bus2.cmd = 1'b0;
        bus2.BG = 1'b1;
        #4;
        chk("sweep.BR1", 64'(bus2.BR), 1);
        chk("sweep.WR0", 64'(bus2.WRITE), 0);
        @(posedge clk);
        #1;
        bus2.edata = 64'h0123_4567_89AB_CDEF;
        #4;
        chk("sweep.WR1", 64'(bus2.WRITE), 1);
        chk("sweep.addr", 64'(bus2.addr), 64'h01F4);
        chk("sweep.offset", 64'(bus2.offset), 0);
        chk("sweep.data", bus2.data, 64'h0123_4567_89AB_CDEF);
        chk("sweep.irq0", 64'(bus2.interrupt), 0);
        @(posedge clk);
        #1;
        #4;
        chk("sweep.irq1", 64'(bus2.interrupt), 1);
        chk("sweep.WRdone", 64'(bus2.WRITE), 0);
        chk("sweep.BRdone", 64'(bus2.BR), 0);
        chk("sweep.addrdone", 64'(bus2.addr), 0);
        @(posedge clk);
        #1;
        bus2.BG = 1'b0;
        #4;
        chk("sweep.irqend", 64'(bus2.interrupt), 0);
        chk("sweep.BRend", 64'(bus2.BR), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_controller.md
# dma_controller

Bus-mastering DMA engine between the external device and data memory in the lab-7 CPU system. A CPU `cmd` pulse starts a transfer. The engine requests the memory bus with `BR` and waits for `BG`. It then copies `NUM_BLOCKS` 4-word blocks from the device into memory starting at `BASE_ADDR`, and raises a one-cycle `interrupt` when finished. It sits downstream of the external device (selects the block via `offset`) and upstream of the memory DMA write port (`WRITE`/`addr`/`data`).

## Interface
- `BASE_ADDR`, 16'h01F4, memory word address of the first block.
- `NUM_BLOCKS`, 3, number of 4-word blocks per transfer (1..4).
- `WRITE_CYCLES`, 6, cycles `WRITE` is held per block (≥1).
- `clk` in 1: clock; all state changes on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `cmd` in 1: start request from CPU; sampled high for one or more cycles.
- `BG` in 1: bus grant from CPU.
- `edata` in 64: block from external device for the current `offset`.
- `BR` out 1: bus request to CPU.
- `WRITE` out 1: memory block-write strobe.
- `addr` out 16: memory word address of the current block.
- `data` out 64: block data to memory.
- `offset` out 2: block index driven to the external device.
- `interrupt` out 1: transfer-complete pulse to CPU.

## Operation
- States: IDLE, REQ, XFER, DONE.
- Registers: block counter `blk` (2 bits) and cycle counter `cyc` (width to hold `WRITE_CYCLES`).
- IDLE:
  - `cmd`=1 → REQ, with `blk`=0 and `cyc`=0.
  - `cmd` is ignored in every other state, including DONE.
- REQ:
  - `BR`=1.
  - `BG`=1 sampled → XFER.
- XFER, `BG`=1:
  - `WRITE`=1; `addr` = `BASE_ADDR` + 4·`blk` (16-bit wrap); `offset`=`blk`.
  - `data`=`edata` (combinational pass-through).
  - `cyc` increments each cycle. When `cyc` reaches `WRITE_CYCLES`−1: `cyc`←0 and `blk`←`blk`+1.
  - If `blk`=`NUM_BLOCKS`−1 at that point → DONE.
- XFER, `BG`=0 (grant revoked):
  - `WRITE`=0 in the same cycle (combinational gate); `BR` stays 1.
  - `cyc`←0, `blk` held.
  - When `BG` returns, the current block restarts from cycle 0.
- DONE:
  - `BR`=0, `WRITE`=0, `interrupt`=1 for exactly one cycle → IDLE.
- Whenever `WRITE`=0: `addr`=0, `data`=0, `offset` holds its last value.
- Reset (`reset_n`=0 at a rising edge), in any state including mid-transfer:
  - state→IDLE; `blk`, `cyc`, `offset`←0.
  - `BR`, `WRITE`, `interrupt`, `addr`, `data` = 0 from that edge on.
  - No interrupt is issued for the aborted transfer.

## Timing
- `cmd` sampled at edge T → `BR`=1 during cycle T+1.
- `BG` sampled 1 at edge G → `WRITE`=1, `offset`=0, `addr`=`BASE_ADDR` during G+1.
- Uninterrupted grant:
  - Block k is written during cycles G+1+k·`WRITE_CYCLES` … G+(k+1)·`WRITE_CYCLES`.
  - `WRITE` stays continuously high across block boundaries; `addr`/`offset` change at the boundary edge.
- `interrupt`=1 during cycle G+1+`NUM_BLOCKS`·`WRITE_CYCLES`; `BR` and `WRITE` are 0 in that cycle.
- `BG` dropping in the same cycle as the last `cyc` count: the block is not complete and restarts.
- `cmd` high in the DONE cycle is ignored. `cmd` held high into IDLE afterwards starts a new transfer.

## Test plan
- Basic transfer (defaults):
  - Stimulus: `cmd` pulse at cycle 10; `BG` follows `BR` with 1-cycle lag.
  - Required: `BR` high from cycle 11; `WRITE` high for 18 consecutive cycles.
  - Required: `addr` 0x01F4 (6 cycles), then 0x01F8 (6), then 0x01FC (6); `offset` 0,1,2.
  - Required: `data` equals `edata` each cycle; single `interrupt` pulse; then `BR`=0.
- Delayed grant:
  - Stimulus: `BG` held low 20 cycles after `BR` rises.
  - Required: `BR` stays 1, `WRITE`=0, `addr`=0 throughout; first write occurs the cycle after `BG` is sampled high.
- Grant revoked:
  - Stimulus: `BG` low for 3 cycles during cycle 4 of block 1.
  - Required: `WRITE` drops immediately; `offset` stays 1.
  - Required: on return, block 1 (addr 0x01F8) is rewritten for a full 6 cycles; total `WRITE`-high cycles = 22.
- `cmd` while busy:
  - Stimulus: extra `cmd` pulses in REQ, XFER and DONE.
  - Required: exactly one transfer and one `interrupt`; return to IDLE.
- Reset mid-transfer:
  - Stimulus: `reset_n`=0 for 1 cycle during block 2.
  - Required: next cycle `BR`=`WRITE`=`interrupt`=0, `addr`=0, `offset`=0; no interrupt follows.
  - Required: a new `cmd` performs a full transfer starting at 0x01F4.
- Parameter sweep:
  - Stimulus: `NUM_BLOCKS`=1 with `WRITE_CYCLES`=1.
  - Required: one `WRITE` cycle at 0x01F4; `interrupt` in cycle G+2.
